lab3_input_conditioner: RTL

- Upstream stage for the lab3 combinational logic: takes raw slide-switch inputs and produces clean, synchronised, debounced levels that drive a, b, c.
- Each bit is synchronised to clk, then debounced by a per-bit counter/FSM.
- Also emits one-cycle rise/fall pulses and an aggregate change strobe for downstream capture logic.
- One clock domain; raw switch inputs are asynchronous to clk.

---
 rtl/lab3_input_conditioner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/lab3_input_conditioner.sv
// Synchronises and debounces WIDTH raw switch bits, emitting rise/fall/changed pulses.
// Define LAB3_EVENT_CNT_EN to add the 8-bit event_cnt output counting changed pulses.
module lab3_input_conditioner #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
`ifdef LAB3_EVENT_CNT_EN
    output logic [7:0]       event_cnt,
`endif
    output logic             changed
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_e;

    logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  s_s;
    state_e                            state_q [WIDTH];
    state_e                            state_d [WIDTH];
    logic [CNT_W-1:0]                  cnt_q   [WIDTH];
    logic [CNT_W-1:0]                  cnt_d   [WIDTH];
    logic [WIDTH-1:0]                  sw_out_q, sw_out_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic                              changed_q, changed_d;

    // Synchroniser shift chains; the oldest stage feeds the debouncer.
    always_comb begin
        sync_d = sync_q;
        s_s    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], sw_in[i]};
            s_s[i]    = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Per-bit debounce FSM; any return to the debounced level restarts the count.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sw_out_d = sw_out_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            case (state_q[i])
                ST_STABLE: begin
                    if (s_s[i] == sw_out_q[i]) begin
                        cnt_d[i] = '0;
                    end else if (DEBOUNCE_CYCLES == 1) begin
                        sw_out_d[i] = s_s[i];
                        cnt_d[i]    = '0;
                        rise_d[i]   = s_s[i];
                        fall_d[i]   = ~s_s[i];
                    end else begin
                        cnt_d[i]   = CNT_ONE;
                        state_d[i] = ST_COUNTING;
                    end
                end
                ST_COUNTING: begin
                    if (s_s[i] == sw_out_q[i]) begin
                        cnt_d[i]   = '0;
                        state_d[i] = ST_STABLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        sw_out_d[i] = s_s[i];
                        cnt_d[i]    = '0;
                        state_d[i]  = ST_STABLE;
                        rise_d[i]   = s_s[i];
                        fall_d[i]   = ~s_s[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    cnt_d[i]   = '0;
                    state_d[i] = ST_STABLE;
                end
            endcase
        end
        changed_d = |(rise_d | fall_d);
    end

    // State, counter, synchroniser and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            sw_out_q  <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync_q    <= sync_d;
            sw_out_q  <= sw_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sw_out  = sw_out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = changed_q;

`ifdef LAB3_EVENT_CNT_EN
    logic [7:0] event_cnt_q, event_cnt_d;

    // Event count tracks changed in the same cycle; wraps naturally at 8 bits.
    always_comb begin
        event_cnt_d = event_cnt_q + {7'd0, changed_d};
    end

    // Event counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            event_cnt_q <= 8'd0;
        end else begin
            event_cnt_q <= event_cnt_d;
        end
    end

    assign event_cnt = event_cnt_q;
`endif

endmodule
